multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the CPU datapath: PC, instruction memory, register file, ALU operand mux and data memory.
- Replaces the single-cycle combinational control with a state machine. Issues fetch/data requests with ready handshakes and pulses PC/IR/register/memory strobes in order.
- Detects illegal opcodes and memory timeouts, and keeps cycle and retired-instruction counters for bring-up.

---
 rtl/multicycle_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control sequencer: fetch/decode/exec/mem/writeback with ready
// handshakes, illegal-opcode and memory-timeout traps, and bring-up counters.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic [1:0]       alu_op,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_NONE   = 3'd0,
    C_R      = 3'd1,
    C_I      = 3'd2,
    C_LOAD   = 3'd3,
    C_STORE  = 3'd4,
    C_BRANCH = 3'd5
  } cls_t;

  state_t           cur, nxt;
  cls_t             cls, cls_nxt;
  logic [1:0]       cause, cause_nxt;
  logic [TMO_W-1:0] tmo;
  logic             tmo_hit;
  logic             stay;
  logic             retire;

  // Ready would be missing for the TIMEOUT-th cycle if it is still low now.
  assign tmo_hit = (tmo == TMO_W'(TIMEOUT - 1));
  assign stay    = (nxt == cur) && ((cur == S_FETCH) || (cur == S_MEM));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur         <= S_IDLE;
      cls         <= C_NONE;
      cause       <= 2'b00;
      tmo         <= '0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      cur   <= nxt;
      cls   <= cls_nxt;
      cause <= cause_nxt;
      if (stay) tmo <= tmo + TMO_W'(1);
      else      tmo <= '0;
      if ((cur != S_IDLE) && (cur != S_TRAP)) cycle_count <= cycle_count + CNT_W'(1);
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    nxt        = cur;
    cls_nxt    = cls;
    cause_nxt  = cause;
    retire     = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_inc     = 1'b0;
    pc_branch  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = 2'b00;

    case (cur)
      S_IDLE: if (run) nxt = S_FETCH;

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_inc   = 1'b1;
          nxt      = S_DECODE;
        end else if (tmo_hit) begin
          nxt       = S_TRAP;
          cause_nxt = 2'b10;
        end
      end

      S_DECODE: begin
        nxt = S_EXEC;
        case (opcode)
          7'b0110011: cls_nxt = C_R;
          7'b0010011: cls_nxt = C_I;
          7'b0000011: cls_nxt = C_LOAD;
          7'b0100011: cls_nxt = C_STORE;
          7'b1100011: cls_nxt = C_BRANCH;
          default: begin
            cls_nxt   = C_NONE;
            nxt       = S_TRAP;
            cause_nxt = 2'b01;
          end
        endcase
      end

      S_EXEC: begin
        case (cls)
          C_R: begin
            alu_op = 2'b10;
            nxt    = S_WB;
          end
          C_I: begin
            alu_op  = 2'b10;
            alu_src = 1'b1;
            nxt     = S_WB;
          end
          C_LOAD, C_STORE: begin
            alu_src = 1'b1;
            nxt     = S_MEM;
          end
          C_BRANCH: begin
            alu_op    = 2'b01;
            pc_branch = alu_zero;
            retire    = 1'b1;
          end
          default: nxt = S_IDLE;
        endcase
      end

      S_MEM: begin
        dmem_req  = 1'b1;
        alu_src   = 1'b1;
        mem_read  = (cls == C_LOAD);
        mem_write = (cls == C_STORE);
        if (dmem_ready) begin
          if (cls == C_LOAD) nxt = S_WB;
          else               retire = 1'b1;
        end else if (tmo_hit) begin
          nxt       = S_TRAP;
          cause_nxt = 2'b10;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls == C_LOAD);
        retire     = 1'b1;
      end

      S_TRAP: nxt = S_TRAP;

      default: nxt = S_IDLE;
    endcase

    // run is only sampled at retirement, so an instruction in flight always completes.
    if (retire) nxt = run ? S_FETCH : S_IDLE;
  end

  assign busy       = (cur != S_IDLE) && (cur != S_TRAP);
  assign trap       = (cur == S_TRAP);
  assign trap_cause = cause;
  assign state      = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its
// expected cycle-by-cycle outputs from the class rules and compared every cycle.
module tb_multicycle_ctrl;

  localparam int unsigned TMO = 4;
  localparam int unsigned CW  = 8;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd6;

  localparam logic [13:0] B_IREQ  = 14'h2000, B_DREQ = 14'h1000, B_IRW  = 14'h0800,
                          B_PCI   = 14'h0400, B_PCB  = 14'h0200, B_MRD  = 14'h0100,
                          B_MWR   = 14'h0080, B_RW   = 14'h0040, B_ASRC = 14'h0020,
                          B_M2R   = 14'h0010, B_AOP10 = 14'h0008, B_AOP01 = 14'h0004,
                          B_BUSY  = 14'h0002, B_TRAP = 14'h0001;
  localparam logic [13:0] M_ALL = 14'h3FFF;
  localparam logic [13:0] M_NA  = 14'h3FD3;  // ALU controls unspecified here

  logic          clk, reset, run, alu_zero, imem_ready, dmem_ready;
  logic [6:0]    opcode;
  logic          imem_req, dmem_req, ir_write, pc_inc, pc_branch, mem_read, mem_write;
  logic          reg_write, alu_src, mem_to_reg, busy, trap;
  logic [1:0]    alu_op, trap_cause;
  logic [2:0]    state;
  logic [CW-1:0] cycle_count, instr_count;
  logic [13:0]   obs;

  multicycle_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .ir_write(ir_write), .pc_inc(pc_inc), .pc_branch(pc_branch),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .alu_op(alu_op), .busy(busy),
    .trap(trap), .trap_cause(trap_cause), .state(state),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  assign obs = {imem_req, dmem_req, ir_write, pc_inc, pc_branch, mem_read, mem_write,
                reg_write, alu_src, mem_to_reg, alu_op, busy, trap};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            vectors = 0;
  int            errors  = 0;
  logic [CW-1:0] mcyc, mins;
  logic [1:0]    mcause;
  bit            idle_next;

  function automatic logic rb();
    return ($urandom & 32'd1) != 32'd0;
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, advance the model.
  task automatic step(input logic [2:0] st, input logic [13:0] es, input logic [13:0] msk,
                      input logic r, input logic ir, input logic dr, input logic z,
                      input logic [6:0] op, input logic ret);
    run = r; imem_ready = ir; dmem_ready = dr; alu_zero = z; opcode = op;
    #1;
    check("state", 32'(state), 32'(st));
    check("strobes", 32'(obs & msk), 32'(es & msk));
    check("trap_cause", 32'(trap_cause), 32'(mcause));
    check("cycle_count", 32'(cycle_count), 32'(mcyc));
    check("instr_count", 32'(instr_count), 32'(mins));
    if (st != ST_IDLE && st != ST_TRAP) mcyc++;
    if (ret) mins++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; run = rb(); imem_ready = 1'b1; dmem_ready = 1'b1; alu_zero = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_strobes", 32'(obs), 32'd0);
    check("rst_cause", 32'(trap_cause), 32'd0);
    check("rst_cycle", 32'(cycle_count), 32'd0);
    check("rst_instr", 32'(instr_count), 32'd0);
    mcyc = '0; mins = '0; mcause = 2'b00;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // res: 0 retired, 1 trapped, 2 abandoned mid-MEM (caller resets).
  task automatic do_instr(input logic [6:0] op, input int fd, input int md, input logic z,
                          input logic ra, input int abort, output int res);
    logic rr, ii, ld, sto, br;
    logic [13:0] es;
    rr = (op == OP_R); ii = (op == OP_I); ld = (op == OP_LD);
    sto = (op == OP_ST); br = (op == OP_BR);
    res = 0;
    for (int k = 0; k < fd && k < int'(TMO); k++)
      step(ST_FETCH, B_IREQ | B_BUSY, M_NA, rb(), 1'b0, rb(), rb(), rop(), 1'b0);
    if (fd >= int'(TMO)) begin mcause = 2'b10; res = 1; return; end
    step(ST_FETCH, B_IREQ | B_IRW | B_PCI | B_BUSY, M_NA, rb(), 1'b1, rb(), rb(), rop(), 1'b0);
    step(ST_DECODE, B_BUSY, M_NA, rb(), rb(), rb(), rb(), op, 1'b0);
    if (!(rr || ii || ld || sto || br)) begin mcause = 2'b01; res = 1; return; end
    es = B_BUSY | ((rr || ii) ? B_AOP10 : 14'd0) | (br ? B_AOP01 : 14'd0)
       | ((ii || ld || sto) ? B_ASRC : 14'd0) | ((br && z) ? B_PCB : 14'd0);
    step(ST_EXEC, es, M_ALL, br ? ra : rb(), rb(), rb(), z, rop(), br);
    if (br) return;
    if (ld || sto) begin
      es = B_BUSY | B_DREQ | B_ASRC | (ld ? B_MRD : B_MWR);
      for (int k = 0; k < md && k < int'(TMO); k++) begin
        if (k == abort) begin res = 2; return; end
        step(ST_MEM, es, M_ALL, rb(), rb(), 1'b0, rb(), rop(), 1'b0);
      end
      if (md >= int'(TMO)) begin mcause = 2'b10; res = 1; return; end
      step(ST_MEM, es, M_ALL, sto ? ra : rb(), rb(), 1'b1, rb(), rop(), sto);
      if (sto) return;
    end
    step(ST_WB, B_BUSY | B_RW | (ld ? B_M2R : 14'd0), M_NA, ra, rb(), rb(), rb(), rop(), 1'b1);
  endtask

  task automatic next_instr(input logic [6:0] op, input int fd, input int md, input logic z,
                            input logic ra, input int abort);
    int res;
    int n;
    if (idle_next) begin
      n = int'($urandom_range(2, 0));
      repeat (n) step(ST_IDLE, 14'd0, M_ALL, 1'b0, rb(), rb(), rb(), rop(), 1'b0);
      step(ST_IDLE, 14'd0, M_ALL, 1'b1, rb(), rb(), rb(), rop(), 1'b0);
    end
    do_instr(op, fd, md, z, ra, abort, res);
    if (res == 1) begin
      repeat (3) step(ST_TRAP, B_TRAP, M_ALL, rb(), rb(), rb(), rb(), rop(), 1'b0);
      do_reset();
      idle_next = 1'b1;
    end else if (res == 2) begin
      do_reset();
      idle_next = 1'b1;
    end else begin
      idle_next = !ra;
    end
  endtask

  function automatic logic [6:0] legal_op();
    case ($urandom_range(4, 0))
      0: return OP_R;
      1: return OP_I;
      2: return OP_LD;
      3: return OP_ST;
      default: return OP_BR;
    endcase
  endfunction

  function automatic int rdly(input int trap_odds);
    if (trap_odds > 0 && $urandom_range(trap_odds - 1, 0) == 0) return int'(TMO);
    return int'($urandom_range(TMO - 1, 0));
  endfunction

  initial begin
    reset = 1'b0; run = 1'b0; opcode = '0; alu_zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    mcyc = '0; mins = '0; mcause = 2'b00;
    @(negedge clk);
    do_reset();
    idle_next = 1'b1;

    next_instr(OP_R,   0,       0,       1'b0, 1'b1, -1);
    next_instr(OP_LD,  0,       3,       rb(), 1'b1, -1);
    next_instr(OP_ST,  0,       0,       rb(), 1'b1, -1);
    next_instr(OP_BR,  0,       0,       1'b1, 1'b1, -1);
    next_instr(OP_BR,  1,       0,       1'b0, 1'b0, -1);
    next_instr(OP_I,   2,       0,       rb(), 1'b1, -1);
    next_instr(OP_BAD, 0,       0,       rb(), 1'b1, -1);
    next_instr(OP_R,   TMO,     0,       rb(), 1'b1, -1);
    next_instr(OP_R,   TMO - 1, 0,       rb(), 1'b1, -1);
    next_instr(OP_LD,  0,       TMO,     rb(), 1'b1, -1);
    next_instr(OP_ST,  0,       TMO - 1, rb(), 1'b0, -1);
    next_instr(OP_ST,  0,       5,       rb(), 1'b1, 2);

    // Long trap-free stretch so both counters wrap.
    repeat (300)
      next_instr(legal_op(), rdly(0), rdly(0), rb(), ($urandom_range(7, 0) != 0), -1);

    repeat (150)
      next_instr(($urandom_range(15, 0) == 0) ? rop() : legal_op(), rdly(24), rdly(24),
                 rb(), ($urandom_range(3, 0) != 0), -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
